// File: rtl/wlm_stream_ctrl_if.sv
// Valid/ready stream bundle for wlm_stream_ctrl: product stream in, reduced results out.
// Tag lanes exist only when WLM_STREAM_TAG_EN is defined.
interface wlm_stream_ctrl_if #(
  parameter int LOGQ = 64,
  parameter int TAGW = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2*LOGQ-1:0]     in_C;
  logic                  out_valid;
  logic                  out_ready;
  logic [LOGQ-1:0]       out_T;

  if (TAGW < 1) begin : g_bad_tagw
    $error("wlm_stream_ctrl_if: TAGW must be >= 1");
  end

`ifdef WLM_STREAM_TAG_EN
  logic [TAGW-1:0]       in_tag;
  logic [TAGW-1:0]       out_tag;

  modport master (output in_valid, in_C, in_tag, out_ready,
                  input  in_ready, out_valid, out_T, out_tag);
  modport slave  (input  in_valid, in_C, in_tag, out_ready,
                  output in_ready, out_valid, out_T, out_tag);
`else
  modport master (output in_valid, in_C, out_ready,
                  input  in_ready, out_valid, out_T);
  modport slave  (input  in_valid, in_C, out_ready,
                  output in_ready, out_valid, out_T);
`endif
endinterface

// File: rtl/wlm_stream_ctrl.sv
// Credit-based stream front-end and result FIFO for a fixed-latency pipelined wlm reducer.
// Optional WLM_STREAM_TAG_EN carries a per-sample tag alongside each result.
module wlm_stream_ctrl #(
  parameter int LOGQ  = 64,
  parameter int LOGQH = 17,
  parameter int LAT   = 7,
  parameter int DEPTH = 8,
  parameter int TAGW  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LOGQH-1:0]     qh_cfg,
  wlm_stream_ctrl_if.slave     s,
  output logic [LOGQH-1:0]     red_qH,
  output logic [2*LOGQ-1:0]    red_C,
  input  logic [LOGQ-1:0]      red_T,
  output logic                 busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + LAT + 1) + 1;

  if (DEPTH != (1 << AW) || DEPTH < LAT + 1 || LAT < 1 || LAT > 32 || TAGW < 1)
  begin : g_bad_param
    $error("wlm_stream_ctrl: need LAT in 1..32, DEPTH power of two >= LAT+1, TAGW >= 1");
  end

  logic [LAT-1:0]   r_vsr;
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_count;
  logic [LOGQ-1:0]  r_mem [DEPTH];

  logic [CW-1:0]    w_inflight;
  logic [CW-1:0]    w_used;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;

  always_comb begin
    w_inflight = '0;
    for (int unsigned i = 0; i < LAT; i++) begin
      w_inflight = w_inflight + CW'(r_vsr[i]);
    end
  end

  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid && s.out_ready;
  assign w_push      = r_vsr[LAT-1];
  // A head leaving this edge frees its slot for the incoming sample, which keeps
  // full rate with DEPTH = LAT+1; occupancy never exceeds DEPTH.
  assign w_used      = CW'(r_count) + w_inflight - CW'(w_pop);
  assign w_in_ready  = !rst && (w_used < CW'(DEPTH));
  assign w_accept    = s.in_valid && w_in_ready;

  assign s.in_ready  = w_in_ready;
  assign s.out_valid = w_out_valid;
  assign s.out_T     = w_out_valid ? r_mem[r_rp] : '0;
  assign red_qH      = qh_cfg;
  assign red_C       = w_accept ? s.in_C : '0;
  assign busy        = (|r_vsr) || (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsr   <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      r_vsr[0] <= w_accept;
      for (int unsigned i = 1; i < LAT; i++) begin
        r_vsr[i] <= r_vsr[i-1];
      end
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= red_T;
  end

`ifdef WLM_STREAM_TAG_EN
  logic [TAGW-1:0]  r_tsr  [LAT];
  logic [TAGW-1:0]  r_tmem [DEPTH];

  always_ff @(posedge clk) begin
    r_tsr[0] <= s.in_tag;
    for (int unsigned i = 1; i < LAT; i++) begin
      r_tsr[i] <= r_tsr[i-1];
    end
    if (w_push) r_tmem[r_wp] <= r_tsr[LAT-1];
  end

  assign s.out_tag = w_out_valid ? r_tmem[r_rp] : '0;
`endif

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && r_count == (AW+1)'(DEPTH)));
`endif
endmodule

// File: tb/tb_wlm_stream_ctrl.sv
// Directed bench for wlm_stream_ctrl with a fixed-latency reducer stand-in.
module tb_wlm_stream_ctrl;
  localparam int LOGQ  = 64;
  localparam int LOGQH = 17;
  localparam int LAT   = 7;
  localparam int DEPTH = 8;
  localparam int TAGW  = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [LOGQH-1:0]    qh_cfg;
  logic [LOGQH-1:0]    red_qH;
  logic [2*LOGQ-1:0]   red_C;
  logic [LOGQ-1:0]     red_T;
  logic                busy;

  wlm_stream_ctrl_if #(.LOGQ(LOGQ), .TAGW(TAGW)) sif ();

  wlm_stream_ctrl #(
    .LOGQ (LOGQ),
    .LOGQH(LOGQH),
    .LAT  (LAT),
    .DEPTH(DEPTH),
    .TAGW (TAGW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .qh_cfg(qh_cfg),
    .s     (sif),
    .red_qH(red_qH),
    .red_C (red_C),
    .red_T (red_T),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [LOGQ-1:0] red_model(input logic [2*LOGQ-1:0] c,
                                                input logic [LOGQH-1:0] qh);
    return (c[2*LOGQ-1:LOGQ] ^ c[LOGQ-1:0]) + {qh, {(LOGQ-LOGQH){1'b0}}};
  endfunction

  // Fixed-latency reducer stand-in: LAT registers from red_C to red_T.
  logic [LOGQ-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= red_model(red_C, red_qH);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign red_T = pipe[LAT-1];

  int n_vec = 0;
  int n_err = 0;

  logic [LOGQ-1:0] exp_q  [$];
  logic [TAGW-1:0] exp_tq [$];

  bit              k_acc, k_pop, k_have;
  logic [LOGQ-1:0] k_t, k_ex;
  logic [TAGW-1:0] k_tg, k_etg;

  // One clock: observe handshakes at the falling edge, track the scoreboard, resume after the rise.
  task automatic tick();
    @(negedge clk);
    k_acc  = sif.in_valid && sif.in_ready;
    k_pop  = sif.out_valid && sif.out_ready;
    k_t    = sif.out_T;
    k_tg   = '0;
    k_ex   = '0;
    k_etg  = '0;
    k_have = 1'b0;
`ifdef WLM_STREAM_TAG_EN
    k_tg = sif.out_tag;
`endif
    if (k_pop && exp_q.size() != 0) begin
      k_have = 1'b1;
      k_ex   = exp_q.pop_front();
      k_etg  = exp_tq.pop_front();
    end
    if (k_acc) begin
      exp_q.push_back(red_model(sif.in_C, qh_cfg));
`ifdef WLM_STREAM_TAG_EN
      exp_tq.push_back(sif.in_tag);
`else
      exp_tq.push_back('0);
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [63:0] qw;
    qw            = 64'h800a000000000001;
    qh_cfg        = qw[63:47];
    rst           = 1'b1;
    sif.in_valid  = 1'b0;
    sif.in_C      = '0;
    sif.out_ready = 1'b0;
`ifdef WLM_STREAM_TAG_EN
    sif.in_tag    = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (sif.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b required 0", sif.in_ready); end
    n_vec++;
    if (red_qH !== 17'h10014) begin n_err++; $display("FAIL reset_red_qH: got %h required 10014", red_qH); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (sif.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b required 0", sif.out_valid); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_vec++;
    if (sif.out_T !== 64'h0) begin n_err++; $display("FAIL reset_out_T: got %h required 0", sif.out_T); end
    n_vec++;
    if (sif.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_in_ready: got %b required 1", sif.in_ready); end
    @(posedge clk);
    #1;
  endtask

  // Send one sample into an idle controller, then measure accept-to-out_valid and the held result.
  task automatic single_sample(input string nm, input logic [2*LOGQ-1:0] c);
    int lat;
    logic [LOGQ-1:0] want;
    want          = red_model(c, qh_cfg);
    sif.out_ready = 1'b0;
    sif.in_valid  = 1'b1;
    sif.in_C      = c;
    tick();
    sif.in_valid  = 1'b0;
    sif.in_C      = '0;
    n_vec++;
    if (!k_acc) begin n_err++; $display("FAIL %s_accept: accepted %b required 1", nm, k_acc); end
    lat = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (sif.out_valid === 1'b1) begin lat = n; break; end
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (lat != LAT) begin n_err++; $display("FAIL %s_latency: got %0d cycles required %0d", nm, lat, LAT); end
    n_vec++;
    if (sif.out_T !== want) begin n_err++; $display("FAIL %s_out_T: got %h required %h", nm, sif.out_T, want); end
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL %s_busy: got %b required 1", nm, busy); end
    @(posedge clk);
    #1;
    repeat (3) tick();
    n_vec++;
    if (k_t !== want || k_pop) begin n_err++; $display("FAIL %s_hold: out_T %h pop %b required %h pop 0", nm, k_t, k_pop, want); end
    sif.out_ready = 1'b1;
    tick();
    n_vec++;
    if (!k_pop || !k_have || k_t !== k_ex) begin n_err++; $display("FAIL %s_pop: out_T %h pop %b required %h", nm, k_t, k_pop, want); end
    @(negedge clk);
    n_vec++;
    if (sif.out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL %s_idle: out_valid %b busy %b required 0 0", nm, sif.out_valid, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    single_sample("single", 128'h82e2e662f728b4fa42485e3a0a5d2f34);
  endtask

  task automatic test_back_to_back();
    int sent, got, cyc;
    bit drove;
    sent = 0; got = 0; cyc = 0;
    sif.out_ready = 1'b1;
    while ((sent < 32 || got < 32) && cyc < 200) begin
      drove        = (sent < 32);
      sif.in_valid = drove;
      sif.in_C     = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      cyc++;
      if (drove) begin
        n_vec++;
        if (!k_acc) begin n_err++; $display("FAIL b2b_in_ready: sample %0d in_ready 0 required 1", sent); end
      end
      if (k_acc) sent++;
      if (k_pop) begin
        got++;
        n_vec++;
        if (!k_have || k_t !== k_ex) begin n_err++; $display("FAIL b2b_result: out_T %h required %h", k_t, k_ex); end
      end
    end
    sif.in_valid = 1'b0;
    n_vec++;
    if (got != 32) begin n_err++; $display("FAIL b2b_count: got %0d results required 32", got); end
  endtask

  task automatic test_backpressure();
    int sent, got, cyc, stalled_acc;
    bit last_ready;
    sent = 0; got = 0; cyc = 0; stalled_acc = 0; last_ready = 1'b1;
    while (got < DEPTH + 20 && cyc < 300) begin
      sif.out_ready = (cyc >= 40);
      sif.in_valid  = (sent < DEPTH + 20);
      sif.in_C      = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      if (cyc == 39) last_ready = k_acc;
      if (k_acc) sent++;
      if (k_acc && cyc < 40) stalled_acc++;
      cyc++;
      if (k_pop) begin
        got++;
        n_vec++;
        if (!k_have || k_t !== k_ex) begin n_err++; $display("FAIL bp_result: out_T %h required %h", k_t, k_ex); end
      end
    end
    sif.in_valid = 1'b0;
    n_vec++;
    if (stalled_acc != DEPTH) begin n_err++; $display("FAIL bp_accepts: got %0d required %0d", stalled_acc, DEPTH); end
    n_vec++;
    if (last_ready) begin n_err++; $display("FAIL bp_in_ready_low: accepted at cycle 39, required in_ready 0"); end
    n_vec++;
    if (got != DEPTH + 20) begin n_err++; $display("FAIL bp_drain: got %0d results required %0d", got, DEPTH + 20); end
  endtask

  task automatic test_random();
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    while (got < 1000 && cyc < 20000) begin
      sif.in_valid  = (sent < 1000) && ($urandom_range(0, 1) == 1);
      sif.in_C      = {$urandom(), $urandom(), $urandom(), $urandom()};
      sif.out_ready = ($urandom_range(0, 1) == 1);
      tick();
      cyc++;
      if (k_acc) sent++;
      if (k_pop) begin
        got++;
        n_vec++;
        if (!k_have || k_t !== k_ex) begin n_err++; $display("FAIL rand_result: out_T %h required %h", k_t, k_ex); end
      end
    end
    sif.in_valid = 1'b0;
    n_vec++;
    if (got != 1000 || exp_q.size() != 0) begin
      n_err++; $display("FAIL rand_count: got %0d results, %0d pending, required 1000 and 0", got, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int sent, cyc, stale;
    sent = 0; cyc = 0; stale = 0;
    sif.out_ready = 1'b0;
    while (sent < 8 && cyc < 30) begin
      sif.in_valid = 1'b1;
      sif.in_C     = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      cyc++;
      if (k_acc) sent++;
    end
    sif.in_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    n_vec++;
    if (sif.out_valid !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL rmid_pre: out_valid %b busy %b required 1 1", sif.out_valid, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (sif.in_ready !== 1'b0) begin n_err++; $display("FAIL rmid_in_ready: got %b required 0", sif.in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_tq.delete();
    @(negedge clk);
    n_vec++;
    if (sif.out_valid !== 1'b0 || busy !== 1'b0 || sif.out_T !== 64'h0) begin
      n_err++; $display("FAIL rmid_cleared: out_valid %b busy %b out_T %h required 0 0 0", sif.out_valid, busy, sif.out_T);
    end
    @(posedge clk);
    #1;
    single_sample("rmid_new", 128'h0123456789abcdef_fedcba9876543210);
    for (int n = 0; n < 10; n++) begin
      tick();
      if (k_pop || k_t !== 64'h0) stale++;
    end
    n_vec++;
    if (stale != 0) begin n_err++; $display("FAIL rmid_stale: %0d stale cycles required 0", stale); end
  endtask

`ifdef WLM_STREAM_TAG_EN
  task automatic test_tags();
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    while (got < 32 && cyc < 2000) begin
      sif.in_valid  = (sent < 32) && ($urandom_range(0, 1) == 1);
      sif.in_tag    = TAGW'(sent);
      sif.in_C      = {$urandom(), $urandom(), $urandom(), $urandom()};
      sif.out_ready = ($urandom_range(0, 1) == 1);
      tick();
      cyc++;
      if (k_acc) sent++;
      if (k_pop) begin
        n_vec++;
        if (!k_have || k_t !== k_ex || k_tg !== TAGW'(got)) begin
          n_err++; $display("FAIL tag_result: tag %h out_T %h required tag %h out_T %h", k_tg, k_t, TAGW'(got), k_ex);
        end
        got++;
      end
    end
    sif.in_valid = 1'b0;
    n_vec++;
    if (got != 32) begin n_err++; $display("FAIL tag_count: got %0d results required 32", got); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef WLM_STREAM_TAG_EN
    test_tags();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required bench completion");
    $fatal(1);
  end
endmodule
